// File: rtl/ram8_arbiter_pkg.sv
// rtl/ram8_arbiter_pkg.sv - shared state encoding and default widths for the RAM8 arbiter
package ram8_arbiter_pkg;

    localparam int DEFAULT_DATA_W = 16;
    localparam int DEFAULT_ADDR_W = 3;
    localparam int CNT_W          = 3;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WAIT   = 2'd2,
        S_DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/ram8_arbiter_rr.sv
// rtl/ram8_arbiter_rr.sv - combinational two-way round-robin pick with one-hot grant
module rr_arbiter2 (
    input  logic       i_req0,
    input  logic       i_req1,
    input  logic       i_last_grant,
    output logic [1:0] o_grant
);

    // On a tie the requester that did not win last time goes first.
    always_comb begin
        o_grant = 2'b00;
        if (i_req0 && i_req1) begin
            o_grant = i_last_grant ? 2'b01 : 2'b10;
        end else if (i_req0) begin
            o_grant = 2'b01;
        end else if (i_req1) begin
            o_grant = 2'b10;
        end
    end

endmodule

// File: rtl/ram8_arbiter.sv
// rtl/ram8_arbiter.sv - two-master round-robin access sequencer for the RAM8 bank
module ram8_arbiter
    import ram8_arbiter_pkg::*;
#(
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int ADDR_W   = DEFAULT_ADDR_W,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              ack0,
    output logic [DATA_W-1:0] rdata0,
    output logic              gnt0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata1,
    output logic              gnt1,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_in,
    output logic              ram_load,
    input  logic [DATA_W-1:0] ram_out,
    output logic              busy
);

    state_t             r_state;
    logic               r_last_grant;
    logic               r_we;
    logic [CNT_W-1:0]   r_cnt;
    logic [ADDR_W-1:0]  r_ram_address;
    logic [DATA_W-1:0]  r_ram_in;
    logic               r_ram_load;
    logic               r_ack0;
    logic               r_ack1;
    logic               r_gnt0;
    logic               r_gnt1;
    logic [DATA_W-1:0]  r_rdata0;
    logic [DATA_W-1:0]  r_rdata1;

    logic [1:0]         w_grant;
    logic               w_sel1;
    logic               w_sel_we;
    logic [ADDR_W-1:0]  w_sel_addr;
    logic [DATA_W-1:0]  w_sel_wdata;

    rr_arbiter2 u_rr (
        .i_req0       (req0),
        .i_req1       (req1),
        .i_last_grant (r_last_grant),
        .o_grant      (w_grant)
    );

    assign w_sel1      = w_grant[1];
    assign w_sel_we    = w_sel1 ? we1    : we0;
    assign w_sel_addr  = w_sel1 ? addr1  : addr0;
    assign w_sel_wdata = w_sel1 ? wdata1 : wdata0;

    // r_last_grant doubles as the owner of the transaction in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_last_grant  <= 1'b1;
            r_we          <= 1'b0;
            r_cnt         <= '0;
            r_ram_address <= '0;
            r_ram_in      <= '0;
            r_ram_load    <= 1'b0;
            r_ack0        <= 1'b0;
            r_ack1        <= 1'b0;
            r_gnt0        <= 1'b0;
            r_gnt1        <= 1'b0;
            r_rdata0      <= '0;
            r_rdata1      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_ram_load <= 1'b0;
                    if (w_grant != 2'b00) begin
                        r_last_grant  <= w_sel1;
                        r_we          <= w_sel_we;
                        r_gnt0        <= w_grant[0];
                        r_gnt1        <= w_grant[1];
                        r_ram_address <= w_sel_addr;
                        if (w_sel_we) begin
                            r_ram_in   <= w_sel_wdata;
                            r_ram_load <= 1'b1;
                        end
                        r_state <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    r_ram_load <= 1'b0;
                    if (r_we) begin
                        r_ack0  <= ~r_last_grant;
                        r_ack1  <= r_last_grant;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt   <= READ_LAT[CNT_W-1:0];
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    r_ram_load <= 1'b0;
                    if (r_cnt == CNT_W'(1)) begin
                        if (r_last_grant) begin
                            r_rdata1 <= ram_out;
                            r_ack1   <= 1'b1;
                        end else begin
                            r_rdata0 <= ram_out;
                            r_ack0   <= 1'b1;
                        end
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                S_DONE: begin
                    r_ram_load <= 1'b0;
                    r_ack0     <= 1'b0;
                    r_ack1     <= 1'b0;
                    r_gnt0     <= 1'b0;
                    r_gnt1     <= 1'b0;
                    r_state    <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign ram_address = r_ram_address;
    assign ram_in      = r_ram_in;
    assign ram_load    = r_ram_load;
    assign ack0        = r_ack0;
    assign ack1        = r_ack1;
    assign gnt0        = r_gnt0;
    assign gnt1        = r_gnt1;
    assign rdata0      = r_rdata0;
    assign rdata1      = r_rdata1;
    assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_ram8_arbiter.sv
// tb/tb_ram8_arbiter.sv - directed self-checking bench for ram8_arbiter with a RAM8 model
module tb_ram8_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, we0, req1, we1;
    logic [2:0]  addr0, addr1;
    logic [15:0] wdata0, wdata1;
    logic        ack0, ack1, gnt0, gnt1;
    logic [15:0] rdata0, rdata1;
    logic [2:0]  ram_address;
    logic [15:0] ram_in;
    logic        ram_load;
    logic [15:0] ram_out;
    logic        busy;

    logic [15:0] mem [8];
    logic        prev_load;
    int          n_checks = 0;
    int          n_errors = 0;
    int          load_cyc[$];
    logic [1:0]  load_gnt[$];

    always #5 clk = ~clk;

    ram8_arbiter #(.DATA_W(16), .ADDR_W(3), .READ_LAT(1)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .ack0(ack0), .rdata0(rdata0), .gnt0(gnt0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .ack1(ack1), .rdata1(rdata1), .gnt1(gnt1),
        .ram_address(ram_address), .ram_in(ram_in), .ram_load(ram_load),
        .ram_out(ram_out), .busy(busy)
    );

    // RAM8 with one-cycle registered read
    always @(posedge clk) begin
        if (ram_load) mem[ram_address] <= ram_in;
        ram_out <= mem[ram_address];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            chk("ack_overlap", {31'd0, ack0 & ack1}, 32'd0);
            chk("load_back_to_back", {31'd0, ram_load & prev_load}, 32'd0);
        end
        prev_load = ram_load;
    end

    initial begin
        for (int i = 0; i < 8; i++) mem[i] = 16'h0000;
        ram_out = 16'h0000;
        prev_load = 1'b0;
        reset = 1'b1;
        req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
        req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
        step(); step();
        chk("rst_ctrl", {26'd0, ack0, ack1, gnt0, gnt1, ram_load, busy}, 32'd0);
        chk("rst_ram", {13'd0, ram_address, ram_in}, 32'd0);
        chk("rst_rdata", {rdata0, rdata1}, 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("idle_ctrl", {26'd0, ack0, ack1, gnt0, gnt1, ram_load, busy}, 32'd0);
        end

        // requester 0 writes BEEF to address 3
        req0 = 1; we0 = 1; addr0 = 3'd3; wdata0 = 16'hBEEF;
        step();
        chk("w0_access", {11'd0, ram_load, ram_address, ram_in, gnt0, gnt1}, {11'd0, 1'b1, 3'd3, 16'hBEEF, 1'b1, 1'b0});
        chk("w0_access_ack", {30'd0, ack0, busy}, 32'd1);
        step();
        chk("w0_done", {28'd0, ram_load, ack0, ack1, gnt0}, {28'd0, 4'b0101});
        req0 = 0;
        step();
        chk("w0_after", {28'd0, ack0, gnt0, busy, ram_load}, 32'd0);
        chk("w0_mem", {16'd0, mem[3]}, {16'd0, 16'hBEEF});

        // requester 1 reads address 3
        req1 = 1; we1 = 0; addr1 = 3'd3;
        step();
        chk("r1_access", {27'd0, ram_load, gnt1, gnt0, ram_address}, {27'd0, 1'b0, 1'b1, 1'b0, 3'd3});
        step();
        chk("r1_wait", {29'd0, ack1, busy, ram_load}, {29'd0, 3'b010});
        step();
        chk("r1_ack", {31'd0, ack1}, 32'd1);
        chk("r1_rdata", {16'd0, rdata1}, {16'd0, 16'hBEEF});
        chk("r1_rdata0_kept", {16'd0, rdata0}, 32'd0);
        req1 = 0;
        step();
        chk("r1_after", {29'd0, ack1, gnt1, busy}, 32'd0);
        chk("r1_rdata_held", {16'd0, rdata1}, {16'd0, 16'hBEEF});

        // both requesters writing continuously from reset
        reset = 1'b1;
        req0 = 1; we0 = 1; addr0 = 3'd1; wdata0 = 16'h1111;
        req1 = 1; we1 = 1; addr1 = 3'd2; wdata1 = 16'h2222;
        step();
        reset = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            step();
            if (ram_load) begin
                load_cyc.push_back(c);
                load_gnt.push_back({gnt1, gnt0});
            end
        end
        req0 = 0; req1 = 0;
        chk("fair_count", load_cyc.size(), 32'd4);
        for (int i = 0; i < load_gnt.size(); i++)
            chk("fair_order", {30'd0, load_gnt[i]}, (i % 2 == 0) ? 32'd1 : 32'd2);
        for (int i = 1; i < load_cyc.size(); i++)
            chk("load_gap", {31'd0, (load_cyc[i] - load_cyc[i-1]) >= 2}, 32'd1);
        step(); step();
        chk("fair_mem", {mem[1], mem[2]}, {16'h1111, 16'h2222});

        // reset during WAIT of a requester 1 read
        req1 = 1; we1 = 0; addr1 = 3'd2;
        step();
        step();
        chk("rw_in_wait", {30'd0, busy, ack1}, 32'd2);
        reset = 1'b1; req1 = 0;
        step();
        chk("rw_reset", {29'd0, ack1, gnt1, busy}, 32'd0);
        chk("rw_rdata1", {16'd0, rdata1}, 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rw_no_ack", {30'd0, ack1, busy}, 32'd0);
        end
        req1 = 1; we1 = 0; addr1 = 3'd2;
        step(); step(); step();
        chk("rw_reread_ack", {31'd0, ack1}, 32'd1);
        chk("rw_reread", {16'd0, rdata1}, {16'd0, 16'h2222});
        req1 = 0;
        step();

        // requester 0 drops req the cycle after sampling
        req0 = 1; we0 = 1; addr0 = 3'd7; wdata0 = 16'h00FF;
        step();
        req0 = 0;
        chk("drop_access", {11'd0, ram_load, ram_address, ram_in, 2'd0}, {11'd0, 1'b1, 3'd7, 16'h00FF, 2'd0});
        step();
        chk("drop_ack", {30'd0, ack0, ack1}, 32'd2);
        step();
        chk("drop_idle", {31'd0, busy}, 32'd0);
        req0 = 1; we0 = 0; addr0 = 3'd7;
        step();
        req0 = 0;
        step(); step();
        chk("drop_read_ack", {31'd0, ack0}, 32'd1);
        chk("drop_read", {rdata0, rdata1}, {16'h00FF, 16'h2222});
        step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
